// File: rtl/banco_registradores.sv
// banco_registradores: 2^ENDERECO_BITS x LARGURA register bank, 1 write port, 2 read ports, pending scoreboard.
// Latency: reads and pending flags are combinational; writes and reservations land at the rising edge.
// Backpressure: none; the decode stage stalls on pendente1/pendente2 and must not reserve an already pending register.
module banco_registradores #(
    parameter int LARGURA       = 32,
    parameter int ENDERECO_BITS = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     escrita_habilitada,
    input  logic [ENDERECO_BITS-1:0] endereco_escrita,
    input  logic [LARGURA-1:0]       dado_escrita,
    input  logic                     reserva_valida,
    input  logic [ENDERECO_BITS-1:0] endereco_reserva,
    input  logic [ENDERECO_BITS-1:0] endereco_leitura1,
    input  logic [ENDERECO_BITS-1:0] endereco_leitura2,
    output logic [LARGURA-1:0]       leitura1,
    output logic [LARGURA-1:0]       leitura2,
    output logic                     pendente1,
    output logic                     pendente2
);

    localparam int NREG = 1 << ENDERECO_BITS;

    logic [LARGURA-1:0] regs_q [NREG];
    logic [NREG-1:0]    pend_q;
    logic [NREG-1:0]    pend_d;
    logic               escrita_valida;

    // Writes to r0 are dropped so the entry stays at its reset value of zero.
    assign escrita_valida = escrita_habilitada && (endereco_escrita != '0);

    // Register array: cleared by reset, written at the edge by the write-back port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (escrita_valida) begin
            regs_q[endereco_escrita] <= dado_escrita;
        end
    end

    // Scoreboard next state: write-back clears, a new reservation sets and wins over the clear.
    always_comb begin
        pend_d = pend_q;
        if (escrita_habilitada) begin
            pend_d[endereco_escrita] = 1'b0;
        end
        if (reserva_valida) begin
            pend_d[endereco_reserva] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read port 1: r0 reads zero, a same-cycle write-back is bypassed and is by definition not pending.
    always_comb begin
        leitura1  = '0;
        pendente1 = 1'b0;
        if (endereco_leitura1 != '0) begin
            if (escrita_habilitada && (endereco_escrita == endereco_leitura1)) begin
                leitura1 = dado_escrita;
            end else begin
                leitura1  = regs_q[endereco_leitura1];
                pendente1 = pend_q[endereco_leitura1];
            end
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        leitura2  = '0;
        pendente2 = 1'b0;
        if (endereco_leitura2 != '0) begin
            if (escrita_habilitada && (endereco_escrita == endereco_leitura2)) begin
                leitura2 = dado_escrita;
            end else begin
                leitura2  = regs_q[endereco_leitura2];
                pendente2 = pend_q[endereco_leitura2];
            end
        end
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Bench for banco_registradores: directed per-cycle vectors plus reset corner sequences.
// Inputs driven on the falling edge, outputs compared 1 ns later, state updates on the next rising edge.
// Each vector describes one clock cycle's inputs and the combinational outputs expected in that cycle.
module tb_banco_registradores;

    logic        clock;
    logic        reset_n;
    logic        escrita_habilitada;
    logic [4:0]  endereco_escrita;
    logic [31:0] dado_escrita;
    logic        reserva_valida;
    logic [4:0]  endereco_reserva;
    logic [4:0]  endereco_leitura1;
    logic [4:0]  endereco_leitura2;
    logic [31:0] leitura1;
    logic [31:0] leitura2;
    logic        pendente1;
    logic        pendente2;

    int passed;
    int total;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rv;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep1;
        logic        ep2;
    } vec_t;

    vec_t vt[$];

    banco_registradores #(.LARGURA(32), .ENDERECO_BITS(5)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .escrita_habilitada(escrita_habilitada),
        .endereco_escrita  (endereco_escrita),
        .dado_escrita      (dado_escrita),
        .reserva_valida    (reserva_valida),
        .endereco_reserva  (endereco_reserva),
        .endereco_leitura1 (endereco_leitura1),
        .endereco_leitura2 (endereco_leitura2),
        .leitura1          (leitura1),
        .leitura2          (leitura2),
        .pendente1         (pendente1),
        .pendente2         (pendente2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic rv, input logic [4:0] ra,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic ep1, input logic ep2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.ep1 = ep1; v.ep2 = ep2;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b, expected %b", name, got, exp);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [4:0] ra,
                         input logic [4:0] a1, input logic [4:0] a2);
        escrita_habilitada = we;
        endereco_escrita   = wa;
        dado_escrita       = wd;
        reserva_valida     = rv;
        endereco_reserva   = ra;
        endereco_leitura1  = a1;
        endereco_leitura2  = a2;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input logic ep1, input logic ep2);
        check32({tag, ".leitura1"}, leitura1, e1);
        check32({tag, ".leitura2"}, leitura2, e2);
        check1({tag, ".pendente1"}, pendente1, ep1);
        check1({tag, ".pendente2"}, pendente2, ep2);
    endtask

    initial begin
        passed = 0;
        total  = 0;

        //              we  wa  wd            rv ra  a1  a2  e1            e2            p1 p2
        // basic writes, r5 bypassed then held, r31 bypassed then held
        vt.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0));
        vt.push_back(mk(1, 31, 32'h00000001, 0, 0,  5,  31, 32'hDEADBEEF, 32'h00000001, 0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  5,  31, 32'hDEADBEEF, 32'h00000001, 0, 0));
        // r0 immunity: write and reserve r0
        vt.push_back(mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  5,  32'h0,        32'hDEADBEEF, 0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  0,  31, 32'h0,        32'h00000001, 0, 0));
        // bypass on r7 (old value 0 still visible on port 2 reading nothing else), then held
        vt.push_back(mk(1, 7,  32'h12345678, 0, 0,  7,  6,  32'h12345678, 32'h0,        0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  7,  5,  32'h12345678, 32'hDEADBEEF, 0, 0));
        // scoreboard on r9: reserve, pending for three cycles, write-back clears in its own cycle
        vt.push_back(mk(0, 0,  32'h0,        1, 9,  0,  9,  32'h0,        32'h0,        0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  0,  9,  32'h0,        32'h0,        0, 1));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h0,        32'h0,        1, 1));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  0,  9,  32'h0,        32'h0,        0, 1));
        vt.push_back(mk(1, 9,  32'h000000A5, 0, 0,  0,  9,  32'h0,        32'h000000A5, 0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h000000A5, 32'h000000A5, 0, 0));
        // simultaneous set/clear on r3: set wins
        vt.push_back(mk(0, 0,  32'h0,        1, 3,  3,  0,  32'h0,        32'h0,        0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h0,        32'h0,        1, 0));
        vt.push_back(mk(1, 3,  32'hCAFE0003, 1, 3,  3,  9,  32'hCAFE0003, 32'h000000A5, 0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  3,  0,  32'hCAFE0003, 32'h0,        1, 0));
        // second reservation of pending r3 keeps it set; the first write-back clears it
        vt.push_back(mk(0, 0,  32'h0,        1, 3,  3,  0,  32'hCAFE0003, 32'h0,        1, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  3,  0,  32'hCAFE0003, 32'h0,        1, 0));
        vt.push_back(mk(1, 3,  32'h00000033, 0, 0,  3,  0,  32'h00000033, 32'h0,        0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  3,  3,  32'h00000033, 32'h00000033, 0, 0));
        // write to a non-pending register leaves its pending bit clear
        vt.push_back(mk(1, 5,  32'h00000055, 0, 0,  0,  5,  32'h0,        32'h00000055, 0, 0));
        vt.push_back(mk(0, 0,  32'h0,        0, 0,  5,  7,  32'h00000055, 32'h12345678, 0, 0));

        // reset held with arbitrary addresses, checked before any clock edge
        reset_n = 1'b0;
        drive(0, 5'd4, 32'h0, 0, 5'd0, 5'd17, 5'd31);
        #3;
        check_all("reset_initial", 32'h0, 32'h0, 0, 0);

        @(negedge clock);
        reset_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clock);
            drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].rv, vt[i].ra, vt[i].a1, vt[i].a2);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, vt[i].ep1, vt[i].ep2);
        end

        // reserve r3 with a value stored, then clear everything with reset and no clock edge
        @(negedge clock);
        drive(0, 0, 32'h0, 1, 5'd3, 5'd3, 5'd5);
        @(negedge clock);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd3, 5'd5);
        #1;
        check_all("pre_reset", 32'h00000033, 32'h00000055, 1, 0);
        #1;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 0, 0);

        // write presented while reset is held is lost
        @(negedge clock);
        drive(1, 5'd12, 32'hBAADF00D, 1, 5'd12, 5'd0, 5'd0);
        @(negedge clock);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd12, 5'd7);
        #1;
        check_all("write_in_reset", 32'h0, 32'h0, 0, 0);

        // first edge after release takes a write
        reset_n = 1'b1;
        drive(1, 5'd12, 32'h0000C0DE, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clock);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd12, 5'd3);
        #1;
        check_all("post_release", 32'h0000C0DE, 32'h0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/banco_registradores.md
# banco_registradores

Register bank for the processor core: 32 × 32-bit general registers with one write port and two read ports. The write port is fed by the register-bank input multiplexer, which selects between the ALU result and memory data. A per-register pending scoreboard tells the decode stage whether a source operand is still waiting for its write-back. Register 0 is hard-wired to zero.

## Interface
- `LARGURA`, 32, data width of each register and of every data port
- `ENDERECO_BITS`, 5, address width; register count is 2^`ENDERECO_BITS`
- `clock` input 1: single clock, all state updates on its rising edge
- `reset_n` input 1: reset, asynchronous, active-low
- `escrita_habilitada` input 1: write-back strobe for this cycle
- `endereco_escrita` input `ENDERECO_BITS`: destination register of the write-back
- `dado_escrita` input `LARGURA`: write-back data (driven by the register-bank input multiplexer)
- `reserva_valida` input 1: decode has issued an instruction that will write `endereco_reserva`
- `endereco_reserva` input `ENDERECO_BITS`: register being reserved
- `endereco_leitura1` input `ENDERECO_BITS`: read port 1 address
- `endereco_leitura2` input `ENDERECO_BITS`: read port 2 address
- `leitura1` output `LARGURA`: read port 1 data (combinational)
- `leitura2` output `LARGURA`: read port 2 data (combinational)
- `pendente1` output 1: read port 1 operand not yet written back (combinational)
- `pendente2` output 1: read port 2 operand not yet written back (combinational)

## Operation
- State:
  - register array `regs[0..2^ENDERECO_BITS-1]`, each `LARGURA` bits
  - pending vector `pend[0..2^ENDERECO_BITS-1]`, 1 bit per register
- Reset (`reset_n`=0, asynchronous):
  - all `regs` and `pend` bits clear to 0 immediately
  - consequently `leitura1`=`leitura2`=0 and `pendente1`=`pendente2`=0 while reset is held, whatever the addresses
- Write: at the rising edge with `escrita_habilitada`=1 and `endereco_escrita`≠0, `regs[endereco_escrita]` ← `dado_escrita`.
  - A write to address 0 is discarded.
  - A write to a register that is not pending is legal and has no side effect on `pend`.
- Read port n:
  - address 0 → data 0 and pending 0, always
  - else, if `escrita_habilitada`=1 and `endereco_escrita`=`endereco_leituran` → data=`dado_escrita` (same-cycle bypass) and pending=0
  - else → data=`regs[addr]` and pending=`pend[addr]`
- Scoreboard update at each rising edge, per address a≠0:
  - set if `reserva_valida`=1 and `endereco_reserva`=a
  - clear if `escrita_habilitada`=1 and `endereco_escrita`=a
  - both on the same a in the same cycle: set wins, because a new producer was issued after the old one retired
  - reservation of address 0 is ignored; `pend[0]` stays 0
- The scoreboard holds one outstanding producer per register. A second reservation of a register that is already pending leaves the bit set, and the first write-back clears it. Decode must stall rather than issue a second writer.

## Timing
- Read data and pending flags are combinational from the addresses, the write port inputs and the state. There are no read latency cycles.
- A write is visible through the bypass in the same cycle, and from `regs` from the next cycle.
- A reservation made at edge k shows as `pendente`=1 from cycle k+1, until the cycle in which the matching write-back is presented (bypass clears it in that cycle).
- Reset deassertion is synchronous to `clock` at system level. The first write can take effect at the first rising edge after `reset_n` goes high.
- Reset asserted mid-write: the write is lost and all state is 0.

## Test plan
- Reset then read: assert `reset_n`=0 with arbitrary addresses → `leitura1`=`leitura2`=0, `pendente1`=`pendente2`=0 without any clock edge.
- Basic write/read: write 0xDEADBEEF to r5, then r31=0x1 → next cycle, addr1=5 and addr2=31 give 0xDEADBEEF / 0x00000001.
- r0 immunity: write 0xFFFFFFFF to r0 and reserve r0 → `leitura1`=0 and `pendente1`=0 on every following cycle.
- Bypass: in one cycle write 0x12345678 to r7 with `endereco_leitura1`=7 → `leitura1`=0x12345678 in that same cycle while r7 still holds the old value.
- Scoreboard: reserve r9 → `pendente2`=1 for addr2=9 from the next cycle. Write r9=0xA5 three cycles later → `pendente2`=0 and `leitura2`=0xA5 in the write cycle, and stays 0 afterwards.
- Simultaneous set/clear: with r3 pending, write r3 and reserve r3 in the same cycle → next cycle `pendente1`=1 for addr1=3 and `leitura1`= the written value. Asserting `reset_n`=0 then clears it to 0 immediately.
